// File: rtl/frame_reduce_accum_pkg.sv
// Shared types for the frame reduction accumulator: FSM states, the per-frame
// result record and the single-beat AND/OR/XOR reduction.
package frame_reduce_pkg;

   localparam int unsigned MAX_DATA_W = 64;
   localparam int unsigned MAX_CNT_W  = 32;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   typedef struct packed {
      logic b_and;
      logic b_or;
      logic b_xor;
   } beat_red_t;

   typedef struct packed {
      logic                 all_ones;
      logic                 any_one;
      logic                 parity;
      logic                 parity_err;
      logic [MAX_CNT_W-1:0] count;
      logic                 count_sat;
   } frame_result_t;

   // Bits at or above 'width' are ignored, so zero-extension cannot break the AND.
   function automatic beat_red_t beat_reduce(input logic [MAX_DATA_W-1:0] data,
                                             input int unsigned           width);
      beat_red_t r;
      r.b_and = 1'b1;
      r.b_or  = 1'b0;
      r.b_xor = 1'b0;
      for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
         if (i < width) begin
            r.b_and = r.b_and & data[i];
            r.b_or  = r.b_or  | data[i];
            r.b_xor = r.b_xor ^ data[i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/frame_reduce_accum_if.sv
// Beat input stream and result record output of the frame reduction accumulator.
// Handshake: a transfer happens on a rising edge where valid && ready; the source
// holds its payload stable while valid && !ready, and ready never depends on valid.
interface frame_reduce_accum_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 16
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_last;
   logic              s_par_exp;
   logic              m_valid;
   logic              m_ready;
   logic              m_all_ones;
   logic              m_any_one;
   logic              m_parity;
   logic              m_parity_err;
   logic [CNT_W-1:0]  m_count;
   logic              m_count_sat;

   modport master (
      output s_valid, s_data, s_last, s_par_exp, m_ready,
      input  s_ready, m_valid, m_all_ones, m_any_one, m_parity, m_parity_err,
             m_count, m_count_sat
   );

   modport slave (
      input  s_valid, s_data, s_last, s_par_exp, m_ready,
      output s_ready, m_valid, m_all_ones, m_any_one, m_parity, m_parity_err,
             m_count, m_count_sat
   );
endinterface

// File: rtl/frame_reduce_accum.sv
// Folds AND/OR/XOR reductions of every beat of a frame into one result record,
// then holds that record until the consumer takes it.
module frame_reduce_accum
   import frame_reduce_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned CNT_W      = 16,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   frame_reduce_accum_if.slave   bus,
   output state_t                o_state
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            r_state;
   logic              r_s_ready;
   logic              r_m_valid;
   logic              r_acc_and;
   logic              r_acc_or;
   logic              r_acc_xor;
   logic [CNT_W-1:0]  r_cnt;
   frame_result_t     r_res;

   logic                  w_accept;
   logic [MAX_DATA_W-1:0] w_data_ext;
   beat_red_t             w_beat;
   logic                  w_and;
   logic                  w_or;
   logic                  w_xor;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic                  w_unused_cnt_hi;

   assign w_accept   = bus.s_valid && r_s_ready;
   assign w_data_ext = MAX_DATA_W'(bus.s_data);
   assign w_beat     = beat_reduce(w_data_ext, DATA_W);
   assign w_and      = r_acc_and & w_beat.b_and;
   assign w_or       = r_acc_or  | w_beat.b_or;
   assign w_xor      = r_acc_xor ^ w_beat.b_xor;
   // Counter sticks at all-ones; reaching it is what marks saturation.
   assign w_cnt_nxt  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ACCUM;
         r_s_ready <= 1'b0;
         r_m_valid <= 1'b0;
         r_acc_and <= 1'b1;
         r_acc_or  <= 1'b0;
         r_acc_xor <= 1'b0;
         r_cnt     <= '0;
         r_res     <= '0;
      end else begin
         case (r_state)
            ACCUM: begin
               r_s_ready <= 1'b1;
               if (w_accept) begin
                  if (bus.s_last) begin
                     r_res.all_ones   <= w_and;
                     r_res.any_one    <= w_or;
                     r_res.parity     <= w_xor;
                     r_res.parity_err <= ((w_xor ^ bus.s_par_exp) != PARITY_ODD);
                     r_res.count      <= MAX_CNT_W'(w_cnt_nxt);
                     r_res.count_sat  <= (w_cnt_nxt == CNT_MAX);
                     r_m_valid        <= 1'b1;
                     r_s_ready        <= 1'b0;
                     r_state          <= HOLD;
                     r_acc_and        <= 1'b1;
                     r_acc_or         <= 1'b0;
                     r_acc_xor        <= 1'b0;
                     r_cnt            <= '0;
                  end else begin
                     r_acc_and <= w_and;
                     r_acc_or  <= w_or;
                     r_acc_xor <= w_xor;
                     r_cnt     <= w_cnt_nxt;
                  end
               end
            end
            HOLD: begin
               // Ready returns only after the record leaves: one bubble between frames.
               if (bus.m_ready) begin
                  r_m_valid <= 1'b0;
                  r_s_ready <= 1'b1;
                  r_state   <= ACCUM;
               end
            end
            default: begin
               r_state   <= ACCUM;
               r_s_ready <= 1'b0;
               r_m_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.s_ready      = r_s_ready;
   assign bus.m_valid      = r_m_valid;
   assign bus.m_all_ones   = r_res.all_ones;
   assign bus.m_any_one    = r_res.any_one;
   assign bus.m_parity     = r_res.parity;
   assign bus.m_parity_err = r_res.parity_err;
   assign bus.m_count      = r_res.count[CNT_W-1:0];
   assign bus.m_count_sat  = r_res.count_sat;
   assign o_state          = r_state;

   // The record's count field is wider than CNT_W; its upper bits are always zero.
   assign w_unused_cnt_hi  = ^r_res.count;

endmodule

// File: tb/tb_frame_reduce_accum.sv
// Drives one beat stream into two instances (16-bit and 4-bit counters) and
// checks every result record against a frame-level reference model.
module tb_frame_reduce_accum;
   import frame_reduce_pkg::*;

   localparam int EXP_W = 26;
   localparam int MAX16 = 65535;
   localparam int MAX4  = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_last = 1'b0;
   logic       s_par_exp = 1'b0;
   logic       m_ready = 1'b0;
   state_t     st16;
   state_t     st4;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0]       cur_q[$];
   logic [EXP_W-1:0] exp_q[$];

   frame_reduce_accum_if #(.DATA_W(8), .CNT_W(16)) bus16 ();
   frame_reduce_accum_if #(.DATA_W(8), .CNT_W(4))  bus4 ();

   assign bus16.s_valid   = s_valid;
   assign bus16.s_data    = s_data;
   assign bus16.s_last    = s_last;
   assign bus16.s_par_exp = s_par_exp;
   assign bus16.m_ready   = m_ready;
   assign bus4.s_valid    = s_valid;
   assign bus4.s_data     = s_data;
   assign bus4.s_last     = s_last;
   assign bus4.s_par_exp  = s_par_exp;
   assign bus4.m_ready    = m_ready;

   frame_reduce_accum #(.DATA_W(8), .CNT_W(16), .PARITY_ODD(1'b0)) dut16 (
      .clk(clk), .rst_n(rst_n), .bus(bus16), .o_state(st16));
   frame_reduce_accum #(.DATA_W(8), .CNT_W(4), .PARITY_ODD(1'b0)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4), .o_state(st4));

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Packed as {all_ones, any_one, parity, err, count16, sat16, count4, sat4}.
   function automatic logic [EXP_W-1:0] model(input logic [7:0] beats[$], input logic pexp);
      int   n    = beats.size();
      int   ones = 0;
      logic all  = 1'b1;
      logic any  = 1'b0;
      logic par;
      logic [15:0] c16;
      logic [3:0]  c4;
      foreach (beats[i]) begin
         ones += $countones(beats[i]);
         if (beats[i] != 8'hFF) all = 1'b0;
         if (beats[i] != 8'h00) any = 1'b1;
      end
      par = (ones % 2) == 1;
      c16 = 16'((n > MAX16) ? MAX16 : n);
      c4  = 4'((n > MAX4) ? MAX4 : n);
      // Even parity expected over data + expected bit.
      return {all, any, par, par ^ pexp, c16, (n >= MAX16), c4, (n >= MAX4)};
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_beat(input logic [7:0] d, input logic last, input logic pexp, input int gap);
      int n = 0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      s_valid = 1'b1; s_data = d; s_last = last; s_par_exp = pexp;
      while (!bus16.s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("s_ready_wait", {31'd0, bus16.s_ready}, 32'd1);
      check("s_ready_wait4", {31'd0, bus4.s_ready}, 32'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0; s_last = $urandom_range(0, 1); s_par_exp = $urandom_range(0, 1);
      s_data = 8'($urandom);
      cur_q.push_back(d);
      if (last) begin
         exp_q.push_back(model(cur_q, pexp));
         cur_q.delete();
      end
   endtask

   task automatic send_frame(input int len, input logic pexp, input int max_gap);
      for (int i = 0; i < len; i++)
         send_beat(8'($urandom), (i == len - 1), pexp, $urandom_range(0, max_gap));
   endtask

   task automatic get_record(input int hold);
      int n = 0;
      logic [EXP_W-1:0] e;
      while (!bus16.m_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("m_valid", {31'd0, bus16.m_valid}, 32'd1);
      check("m_valid4", {31'd0, bus4.m_valid}, 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      for (int c = 0; c <= hold; c++) begin
         check("all_ones",   {31'd0, bus16.m_all_ones},   {31'd0, e[25]});
         check("any_one",    {31'd0, bus16.m_any_one},    {31'd0, e[24]});
         check("parity",     {31'd0, bus16.m_parity},     {31'd0, e[23]});
         check("parity_err", {31'd0, bus16.m_parity_err}, {31'd0, e[22]});
         check("count16",    {16'd0, bus16.m_count},      {16'd0, e[21:6]});
         check("sat16",      {31'd0, bus16.m_count_sat},  {31'd0, e[5]});
         check("count4",     {28'd0, bus4.m_count},       {28'd0, e[4:1]});
         check("sat4",       {31'd0, bus4.m_count_sat},   {31'd0, e[0]});
         check("parity4",    {31'd0, bus4.m_parity},      {31'd0, e[23]});
         check("s_ready_hold", {31'd0, bus16.s_ready}, 32'd0);
         check("state_hold", {31'd0, st16 == HOLD}, 32'd1);
         if (c < hold) @(negedge clk);
      end
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      check("m_valid_drop", {31'd0, bus16.m_valid}, 32'd0);
      check("s_ready_back", {31'd0, bus16.s_ready}, 32'd1);
      check("count_retain", {16'd0, bus16.m_count}, {16'd0, e[21:6]});
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_s_ready",  {31'd0, bus16.s_ready}, 32'd0);
      check("rst_m_valid",  {31'd0, bus16.m_valid}, 32'd0);
      check("rst_count",    {16'd0, bus16.m_count}, 32'd0);
      check("rst_all_ones", {31'd0, bus16.m_all_ones}, 32'd0);
      check("rst_state",    {31'd0, st16 == ACCUM}, 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("s_ready_after_rst", {31'd0, bus16.s_ready}, 32'd1);

      // 1: three all-ones beats, record one cycle after the last beat
      send_beat(8'hFF, 1'b0, 1'b0, 0);
      send_beat(8'hFF, 1'b0, 1'b0, 0);
      check("t1_no_early_valid", {31'd0, bus16.m_valid}, 32'd0);
      send_beat(8'hFF, 1'b1, 1'b0, 0);
      check("t1_latency", {31'd0, bus16.m_valid}, 32'd1);
      get_record(0);

      // 2: single zero beat, odd expected bit
      send_beat(8'h00, 1'b1, 1'b1, 0);
      get_record(0);

      // 3: gaps between beats
      send_beat(8'h01, 1'b0, 1'b0, 3);
      send_beat(8'h80, 1'b0, 1'b0, 3);
      send_beat(8'h03, 1'b1, 1'b0, 3);
      get_record(0);

      // 4: back-pressure for 5 cycles, then next frame goes straight in
      send_frame(4, 1'b1, 0);
      get_record(5);
      send_frame(2, 1'b0, 0);
      get_record(0);

      // 5: long frame saturates the 4-bit counter only
      send_frame(20, 1'b0, 0);
      get_record(1);

      // 6: reset mid-frame discards the partial frame
      send_beat(8'h5A, 1'b0, 1'b0, 0);
      send_beat(8'hA5, 1'b0, 1'b0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      cur_q.delete();
      @(negedge clk);
      check("t6_rst_s_ready", {31'd0, bus16.s_ready}, 32'd0);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("t6_no_stale", {31'd0, bus16.m_valid}, 32'd0);
      end
      send_beat(8'hFF, 1'b1, 1'b0, 0);
      get_record(0);

      // Random frames
      for (int f = 0; f < 12; f++) begin
         send_frame($urandom_range(1, 20), 1'($urandom_range(0, 1)), 2);
         get_record($urandom_range(0, 3));
      end

      check("exp_q_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
